// File: rtl/pchb_mux_sel_sched.sv
// Round-robin select-token scheduler for the two-input PCHB mux.
// Issues one dual-rail select token per transfer, completes the four-phase
// return-to-zero handshake on the synchronised enable, and reports the
// served input with a one-cycle grant pulse and a per-input counter.
module pchb_mux_sel_sched #(
    parameter int SYNC_STAGES = 2,     // SELE synchroniser depth, 2..4
    parameter int TIMEOUT     = 1024,  // cycles per handshake phase before ERR
    parameter int CNT_W       = 16     // grant counter width
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             REQ0,
    input  logic             REQ1,
    output logic [1:0]       SEL,
    input  logic             SELE,
    output logic             GNT0,
    output logic             GNT1,
    output logic             BUSY,
    output logic             ERR,
    output logic [CNT_W-1:0] CNT0,
    output logic [CNT_W-1:0] CNT1
);

    // Phase counter only needs to reach TIMEOUT-1; it saturates there.
    localparam int              PH_W    = $clog2(TIMEOUT);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(TIMEOUT - 1);

    // Dual-rail select encodings.
    localparam logic [1:0] SEL_NEUTRAL = 2'b00;
    localparam logic [1:0] SEL_L0      = 2'b01;
    localparam logic [1:0] SEL_L1      = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_NEUTRAL = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sele_s;
    logic [1:0]             sel_q, sel_d;
    logic                   win_q, win_d;     // 0 = L0 served, 1 = L1 served
    logic                   ptr_q, ptr_d;     // input favoured on contention
    logic                   gnt0_q, gnt0_d;
    logic                   gnt1_q, gnt1_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [CNT_W-1:0]       cnt0_q, cnt0_d;
    logic [CNT_W-1:0]       cnt1_q, cnt1_d;

    // SELE arrives from the QDI mux with no clock relationship; only the
    // last synchroniser stage is ever used by the control logic.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value, which is what makes this a real shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], SELE};
        end
    end

    assign sele_s = sync_q[SYNC_STAGES-1];

    // Handshake FSM next state, arbitration and grant bookkeeping.
    always_comb begin
        // NOTE: every target gets its hold value first so no path through
        // the case statement leaves a signal unassigned (no latches).
        state_d = state_q;
        sel_d   = sel_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;

        unique case (state_q)
            ST_IDLE: begin
                if ((REQ0 || REQ1) && sele_s) begin
                    // A lone request wins outright; contention goes to ptr.
                    win_d   = (REQ0 && REQ1) ? ptr_q : REQ1;
                    sel_d   = win_d ? SEL_L1 : SEL_L0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Enable low means the mux has consumed the token.
                if (!sele_s) begin
                    sel_d   = SEL_NEUTRAL;
                    state_d = ST_NEUTRAL;
                end
            end
            ST_NEUTRAL: begin
                // Enable back high closes the return-to-zero phase.
                if (sele_s) begin
                    if (win_q) begin
                        gnt1_d = 1'b1;
                        cnt1_d = cnt1_q + 1'b1;
                    end else begin
                        gnt0_d = 1'b1;
                        cnt0_d = cnt0_q + 1'b1;
                    end
                    ptr_d   = ~win_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                sel_d   = SEL_NEUTRAL;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Watchdog: count cycles spent in the current handshake phase and latch
    // ERR once a phase has lasted TIMEOUT cycles. The FSM is not disturbed.
    always_comb begin
        phase_d = phase_q;
        err_d   = err_q;
        if (state_d != state_q) begin
            phase_d = '0;
        end else if (state_q != ST_IDLE) begin
            if (phase_q == PH_LAST) begin
                err_d = 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // State and registered outputs; reset forces SEL neutral at once.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_NEUTRAL;
            win_q   <= 1'b0;
            ptr_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            phase_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            phase_q <= phase_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign SEL  = sel_q;
    assign GNT0 = gnt0_q;
    assign GNT1 = gnt1_q;
    assign BUSY = busy_q;
    assign ERR  = err_q;
    assign CNT0 = cnt0_q;
    assign CNT1 = cnt1_q;

endmodule

// File: tb/tb_pchb_mux_sel_sched.sv
// Scoreboard bench for pchb_mux_sel_sched: a transaction-level round-robin
// model predicts each select token and grant, a mux model acknowledges
// tokens with random delays, and monitors compare what the DUT presents.
module tb_pchb_mux_sel_sched;

    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 8;
    localparam int CNT_W       = 2;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             REQ0 = 1'b0;
    logic             REQ1 = 1'b0;
    logic             SELE = 1'b1;
    logic [1:0]       SEL;
    logic             GNT0, GNT1, BUSY, ERR;
    logic [CNT_W-1:0] CNT0, CNT1;

    pchb_mux_sel_sched #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .REQ0   (REQ0),
        .REQ1   (REQ1),
        .SEL    (SEL),
        .SELE   (SELE),
        .GNT0   (GNT0),
        .GNT1   (GNT1),
        .BUSY   (BUSY),
        .ERR    (ERR),
        .CNT0   (CNT0),
        .CNT1   (CNT1)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic             win;
        logic [CNT_W-1:0] c0;
        logic [CNT_W-1:0] c1;
    } grant_t;

    grant_t     gnt_exp_q[$];
    logic [1:0] sel_exp_q[$];

    int   errors = 0;
    int   checks = 0;
    int   issue_cnt = 0;
    int   grant_cnt = 0;
    bit   mon_en = 1'b0;
    bit   hold_sele = 1'b0;
    logic exp_err = 1'b0;

    // Reference model state: round-robin pointer and completed-transfer counts.
    int   m_ptr = 0;
    int   m_c0 = 0;
    int   m_c1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait timed out, got no event, expected one", name);
    endtask

    // Mux model: consume a token some cycles after it appears, then re-arm
    // some cycles after SEL returns to neutral.
    initial begin
        forever begin
            @(negedge CLK);
            if (SEL != 2'b00 && SELE && !hold_sele) begin
                repeat ($urandom_range(0, 3)) @(negedge CLK);
                SELE = 1'b0;
            end else if (SEL == 2'b00 && !SELE) begin
                repeat ($urandom_range(0, 3)) @(negedge CLK);
                SELE = 1'b1;
            end
        end
    end

    // Monitor: token issue, rail legality and grant completion.
    initial begin
        logic [1:0] prev_sel;
        logic [1:0] es;
        grant_t     eg;
        prev_sel = 2'b00;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (SEL == 2'b11) check("sel_rails_exclusive", SEL, 2'b00);
                if (prev_sel != 2'b00 && SEL != 2'b00 && SEL != prev_sel)
                    check("sel_held_stable", SEL, prev_sel);
                if (GNT0 && GNT1) check("gnt_onehot", {GNT1, GNT0}, 2'b01);
                if (prev_sel == 2'b00 && SEL != 2'b00) begin
                    issue_cnt++;
                    if (sel_exp_q.size() == 0) begin
                        check("sel_unexpected_issue", SEL, 2'b00);
                    end else begin
                        es = sel_exp_q.pop_front();
                        check("sel_token", SEL, es);
                        check("busy_on_issue", BUSY, 1'b1);
                    end
                end
                if (GNT0 || GNT1) begin
                    grant_cnt++;
                    if (gnt_exp_q.size() == 0) begin
                        check("gnt_unexpected", {GNT1, GNT0}, 2'b00);
                    end else begin
                        eg = gnt_exp_q.pop_front();
                        check("gnt_which", {GNT1, GNT0}, eg.win ? 2'b10 : 2'b01);
                        check("cnt0", CNT0, eg.c0);
                        check("cnt1", CNT1, eg.c1);
                        check("busy_after_gnt", BUSY, 1'b0);
                        check("err_at_gnt", ERR, exp_err);
                    end
                end
            end
            prev_sel = SEL;
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            #1;
            if (!BUSY) return;
        end
        timeout_fail(name);
    endtask

    // Present one request pattern. A non-zero pattern is held until the
    // resulting token has been issued; the caller's next pattern then
    // overwrites REQ while that handshake is still in progress.
    task automatic txn(input logic [1:0] p);
        int  n;
        int  win;
        bit  seen;
        REQ0 = p[0];
        REQ1 = p[1];
        if (p == 2'b00) begin
            wait_idle("idle_gap");
            repeat (2) @(negedge CLK);
            return;
        end
        win = (p == 2'b11) ? m_ptr : (p == 2'b10 ? 1 : 0);
        if (win == 1) m_c1 = (m_c1 + 1) % (1 << CNT_W);
        else          m_c0 = (m_c0 + 1) % (1 << CNT_W);
        m_ptr = 1 - win;
        sel_exp_q.push_back(win == 1 ? 2'b10 : 2'b01);
        gnt_exp_q.push_back('{win: win[0], c0: m_c0[CNT_W-1:0], c1: m_c1[CNT_W-1:0]});
        n = issue_cnt;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge CLK);
            #1;
            if (issue_cnt != n) seen = 1'b1;
        end
        if (!seen) timeout_fail("issue_wait");
    endtask

    logic [1:0] directed[] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00,
                               2'b01, 2'b00, 2'b10, 2'b00,
                               2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};

    initial begin
        bit seen;

        // Reset state.
        #12;
        check("rst_sel", SEL, 2'b00);
        check("rst_gnt", {GNT1, GNT0}, 2'b00);
        check("rst_busy", BUSY, 1'b0);
        check("rst_err", ERR, 1'b0);
        check("rst_cnt0", CNT0, 0);
        check("rst_cnt1", CNT1, 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Asynchronous reset while a token is being held in ISSUE.
        hold_sele = 1'b1;
        REQ0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK);
            #1;
            if (SEL == 2'b01) seen = 1'b1;
        end
        if (!seen) timeout_fail("pre_reset_issue");
        check("pre_reset_busy", BUSY, 1'b1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_rst_sel", SEL, 2'b00);
        check("async_rst_busy", BUSY, 1'b0);
        check("async_rst_cnt0", CNT0, 0);
        check("async_rst_err", ERR, 1'b0);
        REQ0 = 1'b0;
        hold_sele = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);

        // Directed patterns then random traffic through the scoreboard.
        mon_en = 1'b1;
        foreach (directed[i]) txn(directed[i]);
        for (int i = 0; i < 80; i++) txn(2'($urandom_range(0, 3)));
        txn(2'b00);

        // Watchdog: enable held high after the token is issued.
        wait_idle("pre_watchdog_idle");
        repeat (4) @(negedge CLK);
        hold_sele = 1'b1;
        #1;
        txn(2'b10);
        REQ1 = 1'b0;
        repeat (TIMEOUT - 1) @(posedge CLK);
        @(negedge CLK);
        check("wd_err_not_yet", ERR, 1'b0);
        @(negedge CLK);
        check("wd_err_set", ERR, 1'b1);
        check("wd_sel_held", SEL, 2'b10);
        check("wd_busy", BUSY, 1'b1);
        exp_err = 1'b1;
        hold_sele = 1'b0;
        wait_idle("wd_completion");
        repeat (2) @(negedge CLK);
        check("wd_err_sticky", ERR, 1'b1);

        check("sel_queue_drained", sel_exp_q.size(), 0);
        check("gnt_queue_drained", gnt_exp_q.size(), 0);
        check("issue_vs_grant", issue_cnt, grant_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pchb_mux_sel_sched.md
Name: pchb_mux_sel_sched

Overview:
- Clocked round-robin scheduler that drives the dual-rail select channel (SEL/SELE) of the two-input PCHB mux in the router datapath.
- Takes per-input request levels from the input-port logic and issues one select token per transfer. It then completes the four-phase return-to-zero handshake and reports which input was served.
- Bridges the synchronous control domain to the QDI mux; SELE is synchronised internally.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the SELE synchroniser (legal values 2 to 4).
- TIMEOUT, 1024, cycles allowed per handshake phase before the watchdog error fires (legal values 2 to 65535).
- CNT_W, 16, width of each per-input grant counter.

Ports:
- CLK  input  1  system clock; all state is updated on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- REQ0  input  1  input L0 holds a valid token awaiting transfer (level).
- REQ1  input  1  input L1 holds a valid token awaiting transfer (level).
- SEL  output  2  dual-rail select to the mux: 01 selects L0, 10 selects L1, 00 is neutral. 11 is never driven.
- SELE  input  1  mux select-channel enable (asynchronous). 1 means ready for a token; 0 means the token has been consumed.
- GNT0  output  1  one-cycle pulse: an L0 transfer has completed its full handshake.
- GNT1  output  1  one-cycle pulse: an L1 transfer has completed its full handshake.
- BUSY  output  1  high while not in IDLE.
- ERR  output  1  sticky watchdog error flag.
- CNT0  output  CNT_W  number of completed L0 transfers.
- CNT1  output  CNT_W  number of completed L1 transfers.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - SEL=00; GNT0, GNT1, BUSY and ERR all 0; CNT0 and CNT1 both 0.
  - State goes to IDLE; priority pointer is set to L0; synchroniser flops are cleared to 0.
- Reset asserted mid-handshake forces SEL=00 immediately, without waiting for a clock edge.
- SELE_S is SELE after SYNC_STAGES flops. All decisions use SELE_S only.
- SEL, GNTx and BUSY are registered outputs.
- State machine:
  - IDLE: if REQ0|REQ1 is high and SELE_S=1, pick the winner, register SEL, and go to ISSUE. Otherwise stay.
  - ISSUE: hold SEL. When SELE_S=0 (token consumed), drive SEL=00 and go to NEUTRAL.
  - NEUTRAL: hold SEL=00. When SELE_S=1, pulse GNTx for the winner, increment CNTx, flip the pointer to the other input, and go to IDLE.
- Arbitration:
  - If only one request is high, it wins.
  - If both are high, the input indicated by the pointer wins.
  - The pointer only advances on completion, so back-to-back contention alternates L0, L1, L0, ...
- REQx is sampled only in IDLE. A request dropping during ISSUE or NEUTRAL does not abort the handshake.
- Minimum latency, from REQ high to SEL valid, is 1 cycle when SELE_S is already 1.
- Minimum transfer period is 3 cycles plus 2×SYNC_STAGES of synchroniser delay.
- SEL changes only in these places: IDLE→ISSUE (00→01 or 00→10), ISSUE→NEUTRAL (→00), and reset. A data rail never toggles while the select value is held.
- Counters wrap modulo 2^CNT_W with no saturation.
- Watchdog:
  - A phase counter clears on every state change.
  - If the FSM stays in ISSUE or NEUTRAL for TIMEOUT consecutive cycles, ERR is set to 1.
  - ERR stays high until reset. The FSM keeps waiting in its current state.
- At most one GNT pulse is asserted in any cycle. GNT0 and GNT1 are never both high.

Test Plan:
- Reset: RESET_N=0 while SEL=01 in ISSUE → SEL=00 asynchronously; CNT0=CNT1=0; ERR=0.
- Single request: REQ0=1, SELE=1 → SEL=01. Drop SELE → SEL=00. Raise SELE → GNT0 pulses for 1 cycle, CNT0=1, BUSY returns to 0.
- Contention: REQ0=REQ1=1 held, mux model acking each token → SEL sequence 01,00,10,00,01,00,10,00; CNT0=CNT1=2 after four transfers.
- Request withdrawn: REQ1=1 granted (SEL=10), then REQ1=0 in ISSUE → handshake still completes; GNT1 pulses; CNT1 increments.
- Watchdog: TIMEOUT=8, SELE held at 1 after the token is issued → ERR=1 after 8 cycles in ISSUE, SEL remains 10. A later SELE=0 completes the handshake normally, and ERR stays 1.
- Counter wrap: CNT_W=2, five L0 transfers → CNT0 reads 1,2,3,0,1.
